// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared widths, opcode patterns, ALU op codes and the stage control bundle for the LEGv8 pipelined control unit.
// CTRL_BYTE_XFER_EN adds the LDURB/STURB opcode patterns and the byte transfer size.
package pipe_ctrl_unit_pkg;

  localparam int unsigned OPCODE_W = 11;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned XFER_W   = 4;

  localparam logic [OPCODE_W-1:0] OP_ADDI = 11'b1001000100?;
  localparam logic [OPCODE_W-1:0] OP_ADDS = 11'b10101011000;
  localparam logic [OPCODE_W-1:0] OP_SUBS = 11'b11101011000;
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OPCODE_W-1:0] OP_CBZ  = 11'b10110100???;
  localparam logic [OPCODE_W-1:0] OP_B    = 11'b000101?????;
  localparam logic [OPCODE_W-1:0] OP_BL   = 11'b100101?????;
  localparam logic [OPCODE_W-1:0] OP_BLT  = 11'b01010100???;
  localparam logic [OPCODE_W-1:0] OP_BR   = 11'b11010110000;
`ifdef CTRL_BYTE_XFER_EN
  localparam logic [OPCODE_W-1:0] OP_LDURB = 11'b00111000010;
  localparam logic [OPCODE_W-1:0] OP_STURB = 11'b00111000000;
  localparam logic [XFER_W-1:0]   XFER_BYTE = 4'b0001;
`endif

  localparam logic [2:0]        ALUOP_CBZ  = 3'b000;
  localparam logic [2:0]        ALUOP_ADD  = 3'b010;
  localparam logic [2:0]        ALUOP_SUB  = 3'b011;
  localparam logic [XFER_W-1:0] XFER_DWORD = 4'b1000;
  localparam logic [REG_W-1:0]  LINK_REG   = 5'd30;

  typedef enum logic [3:0] {
    I_ILLEGAL, I_ADDI, I_ADDS, I_SUBS, I_LDUR, I_STUR, I_CBZ,
    I_B, I_BL, I_BLT, I_BR, I_LDURB, I_STURB
  } instr_t;

  typedef struct packed {
    logic              alu_src;
    logic              d_type;
    logic [2:0]        aluop;
    logic              update_flags;
    logic              mem_read;
    logic              mem_write;
    logic [XFER_W-1:0] xfer;
    logic              reg_write;
    logic              mem2reg;
    logic              store_pc;
    logic [REG_W-1:0]  rd;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage instruction fields in, per-stage control and PC/IF steering out.
interface pipe_ctrl_unit_if;
  import pipe_ctrl_unit_pkg::*;

  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rn;
  logic [REG_W-1:0]    id_rm;
  logic [REG_W-1:0]    id_rt;
  logic                id_is_zero;
  logic                id_is_less;
  logic                id_reg2loc;
  logic                pc_src;
  logic                uncond_br;
  logic                pc_from_reg;
  logic                pc_write;
  logic                ifid_write;
  logic                if_flush;
  ctrl_bundle_t        ex_ctrl;
  ctrl_bundle_t        mem_ctrl;
  ctrl_bundle_t        wb_ctrl;
  logic                ex_illegal;

  modport master (
    output id_opcode, id_rn, id_rm, id_rt, id_is_zero, id_is_less,
    input  id_reg2loc, pc_src, uncond_br, pc_from_reg, pc_write, ifid_write,
           if_flush, ex_ctrl, mem_ctrl, wb_ctrl, ex_illegal
  );

  modport slave (
    input  id_opcode, id_rn, id_rm, id_rt, id_is_zero, id_is_less,
    output id_reg2loc, pc_src, uncond_br, pc_from_reg, pc_write, ifid_write,
           if_flush, ex_ctrl, mem_ctrl, wb_ctrl, ex_illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decode: opcode to control bundle, register-source usage and raw branch requests.
// CTRL_BYTE_XFER_EN enables LDURB/STURB; otherwise they decode as illegal.
module pipe_ctrl_unit_decode
  import pipe_ctrl_unit_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [REG_W-1:0]    rt_i,
  input  logic                is_zero_i,
  input  logic                is_less_i,
  output ctrl_bundle_t        ctrl_o,
  output logic                illegal_o,
  output logic                reg2loc_o,
  output logic                use_rn_o,
  output logic                use_rm_o,
  output logic                use_rt_o,
  output logic                is_blt_o,
  output logic                pc_src_o,
  output logic                uncond_br_o,
  output logic                pc_from_reg_o
);

  instr_t cls;

  always_comb begin
    cls = I_ILLEGAL;
    casez (opcode_i)
      OP_ADDI:  cls = I_ADDI;
      OP_ADDS:  cls = I_ADDS;
      OP_SUBS:  cls = I_SUBS;
      OP_LDUR:  cls = I_LDUR;
      OP_STUR:  cls = I_STUR;
      OP_CBZ:   cls = I_CBZ;
      OP_B:     cls = I_B;
      OP_BL:    cls = I_BL;
      OP_BLT:   cls = I_BLT;
      OP_BR:    cls = I_BR;
`ifdef CTRL_BYTE_XFER_EN
      OP_LDURB: cls = I_LDURB;
      OP_STURB: cls = I_STURB;
`endif
      default:  cls = I_ILLEGAL;
    endcase
  end

  always_comb begin
    ctrl_o        = BUBBLE;
    illegal_o     = 1'b0;
    reg2loc_o     = 1'b0;
    use_rn_o      = 1'b0;
    use_rm_o      = 1'b0;
    use_rt_o      = 1'b0;
    is_blt_o      = 1'b0;
    pc_src_o      = 1'b0;
    uncond_br_o   = 1'b0;
    pc_from_reg_o = 1'b0;
    unique case (cls)
      I_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.aluop     = ALUOP_ADD;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.rd        = rt_i;
        use_rn_o         = 1'b1;
      end
      I_ADDS, I_SUBS: begin
        ctrl_o.aluop        = (cls == I_SUBS) ? ALUOP_SUB : ALUOP_ADD;
        ctrl_o.update_flags = 1'b1;
        ctrl_o.reg_write    = 1'b1;
        ctrl_o.rd           = rt_i;
        use_rn_o            = 1'b1;
        use_rm_o            = 1'b1;
      end
      I_LDUR, I_LDURB: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.d_type    = 1'b1;
        ctrl_o.aluop     = ALUOP_ADD;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.xfer      = XFER_DWORD;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem2reg   = 1'b1;
        ctrl_o.rd        = rt_i;
        use_rn_o         = 1'b1;
      end
      I_STUR, I_STURB: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.d_type    = 1'b1;
        ctrl_o.aluop     = ALUOP_ADD;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.xfer      = XFER_DWORD;
        ctrl_o.rd        = rt_i;
        reg2loc_o        = 1'b1;
        use_rn_o         = 1'b1;
        use_rt_o         = 1'b1;
      end
      I_CBZ: begin
        ctrl_o.aluop = ALUOP_CBZ;
        ctrl_o.rd    = rt_i;
        reg2loc_o    = 1'b1;
        use_rt_o     = 1'b1;
        pc_src_o     = is_zero_i;
      end
      I_B: begin
        ctrl_o.rd   = rt_i;
        pc_src_o    = 1'b1;
        uncond_br_o = 1'b1;
      end
      I_BL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.store_pc  = 1'b1;
        ctrl_o.rd        = LINK_REG;
        pc_src_o         = 1'b1;
        uncond_br_o      = 1'b1;
      end
      I_BLT: begin
        ctrl_o.rd = rt_i;
        is_blt_o  = 1'b1;
        pc_src_o  = is_less_i;
      end
      I_BR: begin
        ctrl_o.rd     = rt_i;
        use_rm_o      = 1'b1;
        pc_from_reg_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
`ifdef CTRL_BYTE_XFER_EN
    if (cls == I_LDURB || cls == I_STURB) ctrl_o.xfer = XFER_BYTE;
`endif
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// LEGv8 pipelined control: ID/EX, EX/MEM, MEM/WB control registers plus load-use and flag-use hazard stall.
// Build option CTRL_BYTE_XFER_EN (handled in the decoder) adds LDURB/STURB.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_REG = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  pipe_ctrl_unit_if.slave pif
);

  ctrl_bundle_t dec_ctrl;
  logic         dec_illegal, dec_reg2loc, use_rn, use_rm, use_rt, is_blt;
  logic         br_pc_src, br_uncond, br_from_reg;

  ctrl_bundle_t ex_q, ex_d, mem_q, wb_q;
  logic         ex_ill_q, ex_ill_d;
  logic         rd_hit, load_use, flag_use, stall;

  pipe_ctrl_unit_decode u_decode (
    .opcode_i      (pif.id_opcode),
    .rt_i          (pif.id_rt),
    .is_zero_i     (pif.id_is_zero),
    .is_less_i     (pif.id_is_less),
    .ctrl_o        (dec_ctrl),
    .illegal_o     (dec_illegal),
    .reg2loc_o     (dec_reg2loc),
    .use_rn_o      (use_rn),
    .use_rm_o      (use_rm),
    .use_rt_o      (use_rt),
    .is_blt_o      (is_blt),
    .pc_src_o      (br_pc_src),
    .uncond_br_o   (br_uncond),
    .pc_from_reg_o (br_from_reg)
  );

  always_comb begin
    rd_hit   = (ex_q.rd != ZERO_REG) &&
               ((use_rn && ex_q.rd == pif.id_rn) ||
                (use_rm && ex_q.rd == pif.id_rm) ||
                (use_rt && ex_q.rd == pif.id_rt));
    load_use = ex_q.mem_read && rd_hit;
    flag_use = is_blt && ex_q.update_flags;
    stall    = load_use || flag_use;
    // Illegal opcodes already decode to BUBBLE, so only the stall needs to override here.
    ex_d     = stall ? BUBBLE : dec_ctrl;
    ex_ill_d = dec_illegal && !stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= BUBBLE;
      mem_q    <= BUBBLE;
      wb_q     <= BUBBLE;
      ex_ill_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      ex_ill_q <= ex_ill_d;
    end
  end

  assign pif.id_reg2loc  = dec_reg2loc;
  assign pif.pc_src      = br_pc_src && !stall;
  assign pif.uncond_br   = br_uncond && !stall;
  assign pif.pc_from_reg = br_from_reg && !stall;
  assign pif.if_flush    = (br_pc_src || br_from_reg) && !stall;
  assign pif.pc_write    = !stall;
  assign pif.ifid_write  = !stall;
  assign pif.ex_ctrl     = ex_q;
  assign pif.mem_ctrl    = mem_q;
  assign pif.wb_ctrl     = wb_q;
  assign pif.ex_illegal  = ex_ill_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode vector table, hazard/reset sequences, and random stream against a pipeline model.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_unit_pkg::*;

  typedef enum int {
    K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_CBZ, K_B, K_BL, K_BLT, K_BR, K_LDURB, K_STURB, K_ILL
  } kind_t;

  typedef struct {
    string        nm;
    logic [10:0]  op;
    logic         z;
    logic         l;
    logic [5:0]   fl;   // {pc_src, uncond_br, pc_from_reg, if_flush, reg2loc, ex_illegal}
    ctrl_bundle_t ex;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if pif ();

  pipe_ctrl_unit #(.ZERO_REG(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rt, input logic z, input logic l);
    pif.id_opcode  = op;
    pif.id_rn      = rn;
    pif.id_rm      = rm;
    pif.id_rt      = rt;
    pif.id_is_zero = z;
    pif.id_is_less = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic ctrl_bundle_t mk(bit as, bit dt, logic [2:0] op, bit uf, bit mr, bit mw,
                                      logic [3:0] xf, bit rw, bit m2r, bit sp, logic [4:0] rd);
    ctrl_bundle_t b;
    b.alu_src = as; b.d_type = dt; b.aluop = op; b.update_flags = uf;
    b.mem_read = mr; b.mem_write = mw; b.xfer = xf; b.reg_write = rw;
    b.mem2reg = m2r; b.store_pc = sp; b.rd = rd;
    return b;
  endfunction

  function automatic vec_t mkv(string nm, logic [10:0] op, logic z, logic l, logic [5:0] fl, ctrl_bundle_t ex);
    vec_t v;
    v.nm = nm; v.op = op; v.z = z; v.l = l; v.fl = fl; v.ex = ex;
    return v;
  endfunction

  // Reference bundle per instruction kind, written straight from the decode table.
  function automatic ctrl_bundle_t kind_bundle(kind_t k, logic [4:0] rt);
    case (k)
      K_ADDI:  return mk(1, 0, 3'b010, 0, 0, 0, 4'b0000, 1, 0, 0, rt);
      K_ADDS:  return mk(0, 0, 3'b010, 1, 0, 0, 4'b0000, 1, 0, 0, rt);
      K_SUBS:  return mk(0, 0, 3'b011, 1, 0, 0, 4'b0000, 1, 0, 0, rt);
      K_LDUR:  return mk(1, 1, 3'b010, 0, 1, 0, 4'b1000, 1, 1, 0, rt);
      K_STUR:  return mk(1, 1, 3'b010, 0, 0, 1, 4'b1000, 0, 0, 0, rt);
      K_LDURB: return mk(1, 1, 3'b010, 0, 1, 0, 4'b0001, 1, 1, 0, rt);
      K_STURB: return mk(1, 1, 3'b010, 0, 0, 1, 4'b0001, 0, 0, 0, rt);
      K_BL:    return mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 1, 0, 1, 5'd30);
      K_ILL:   return '0;
      default: return mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, rt);
    endcase
  endfunction

  function automatic bit reads_rn(kind_t k);
    return k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_LDURB, K_STURB};
  endfunction
  function automatic bit reads_rm(kind_t k);
    return k inside {K_ADDS, K_SUBS, K_BR};
  endfunction
  function automatic bit reads_rt(kind_t k);
    return k inside {K_STUR, K_STURB, K_CBZ};
  endfunction

  function automatic logic [10:0] make_op(kind_t k);
    logic [4:0]  r;
    logic [10:0] ill [$];
    r = 5'($urandom);
    ill = '{11'h000, 11'h7FF, 11'b01000000000};
`ifndef CTRL_BYTE_XFER_EN
    ill.push_back(11'b00111000010);
    ill.push_back(11'b00111000000);
`endif
    case (k)
      K_ADDI:  return {10'b1001000100, r[0]};
      K_ADDS:  return 11'b10101011000;
      K_SUBS:  return 11'b11101011000;
      K_LDUR:  return 11'b11111000010;
      K_STUR:  return 11'b11111000000;
      K_CBZ:   return {8'b10110100, r[2:0]};
      K_B:     return {6'b000101, r};
      K_BL:    return {6'b100101, r};
      K_BLT:   return {8'b01010100, r[2:0]};
      K_BR:    return 11'b11010110000;
      K_LDURB: return 11'b00111000010;
      K_STURB: return 11'b00111000000;
      default: return ill[$urandom_range(0, ill.size() - 1)];
    endcase
  endfunction

  vec_t         tbl [$];
  kind_t        pool [$];
  logic [4:0]   regs [4];
  ctrl_bundle_t m_ex, m_mem, m_wb, exp_b;
  bit           m_ill, lu, fu, st, br_rel, br_raw, hold;
  kind_t        k;
  logic [10:0]  op;
  logic [4:0]   rn, rm, rt;
  logic         z, l;

  initial begin
    drive(11'b10101011000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    // Reset held for two cycles with ADDS in ID.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ex", 32'(pif.ex_ctrl), 32'd0);
    chk("rst_mem", 32'(pif.mem_ctrl), 32'd0);
    chk("rst_wb", 32'(pif.wb_ctrl), 32'd0);
    chk("rst_ill", 32'(pif.ex_illegal), 32'd0);
    chk("rst_pcw", 32'(pif.pc_write), 32'd1);
    chk("rst_ifidw", 32'(pif.ifid_write), 32'd1);
    chk("rst_flush", 32'(pif.if_flush), 32'd0);
    reset = 1'b0;

    tbl.push_back(mkv("addi",  11'b10010001000, 0, 0, 6'b000000, mk(1, 0, 3'b010, 0, 0, 0, 4'b0000, 1, 0, 0, 5'd7)));
    tbl.push_back(mkv("adds",  11'b10101011000, 0, 0, 6'b000000, mk(0, 0, 3'b010, 1, 0, 0, 4'b0000, 1, 0, 0, 5'd7)));
    tbl.push_back(mkv("subs",  11'b11101011000, 0, 0, 6'b000000, mk(0, 0, 3'b011, 1, 0, 0, 4'b0000, 1, 0, 0, 5'd7)));
    tbl.push_back(mkv("ldur",  11'b11111000010, 0, 0, 6'b000000, mk(1, 1, 3'b010, 0, 1, 0, 4'b1000, 1, 1, 0, 5'd7)));
    tbl.push_back(mkv("stur",  11'b11111000000, 0, 0, 6'b000010, mk(1, 1, 3'b010, 0, 0, 1, 4'b1000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("cbz_t", 11'b10110100101, 1, 0, 6'b100110, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("cbz_n", 11'b10110100000, 0, 1, 6'b000010, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("b",     11'b00010110011, 0, 0, 6'b110100, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("bl",    11'b10010100000, 0, 0, 6'b110100, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 1, 0, 1, 5'd30)));
    tbl.push_back(mkv("blt_t", 11'b01010100000, 0, 1, 6'b100100, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("blt_n", 11'b01010100000, 1, 0, 6'b000000, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("br",    11'b11010110000, 0, 0, 6'b001100, mk(0, 0, 3'b000, 0, 0, 0, 4'b0000, 0, 0, 0, 5'd7)));
    tbl.push_back(mkv("ill",   11'b00000000000, 0, 0, 6'b000001, '0));
`ifdef CTRL_BYTE_XFER_EN
    tbl.push_back(mkv("ldurb", 11'b00111000010, 0, 0, 6'b000000, mk(1, 1, 3'b010, 0, 1, 0, 4'b0001, 1, 1, 0, 5'd7)));
    tbl.push_back(mkv("sturb", 11'b00111000000, 0, 0, 6'b000010, mk(1, 1, 3'b010, 0, 0, 1, 4'b0001, 0, 0, 0, 5'd7)));
`else
    tbl.push_back(mkv("ldurb", 11'b00111000010, 0, 0, 6'b000001, '0));
    tbl.push_back(mkv("sturb", 11'b00111000000, 0, 0, 6'b000001, '0));
`endif

    foreach (tbl[i]) begin
      do_reset();
      drive(tbl[i].op, 5'd1, 5'd2, 5'd7, tbl[i].z, tbl[i].l);
      #1;
      chk({tbl[i].nm, "_pcsrc"}, 32'(pif.pc_src), 32'(tbl[i].fl[5]));
      chk({tbl[i].nm, "_uncond"}, 32'(pif.uncond_br), 32'(tbl[i].fl[4]));
      chk({tbl[i].nm, "_fromreg"}, 32'(pif.pc_from_reg), 32'(tbl[i].fl[3]));
      chk({tbl[i].nm, "_flush"}, 32'(pif.if_flush), 32'(tbl[i].fl[2]));
      chk({tbl[i].nm, "_reg2loc"}, 32'(pif.id_reg2loc), 32'(tbl[i].fl[1]));
      chk({tbl[i].nm, "_pcw"}, 32'(pif.pc_write), 32'd1);
      tick();
      chk({tbl[i].nm, "_ex"}, 32'(pif.ex_ctrl), 32'(tbl[i].ex));
      chk({tbl[i].nm, "_exill"}, 32'(pif.ex_illegal), 32'(tbl[i].fl[0]));
    end

    // LDUR X2 then ADDS X3,X2,X1: one stall cycle, bubble, then ADDS; load reaches WB 3 cycles after ID.
    do_reset();
    drive(11'b11111000010, 5'd1, 5'd0, 5'd2, 0, 0);
    #1 chk("lu_first_pcw", 32'(pif.pc_write), 32'd1);
    tick();
    drive(11'b10101011000, 5'd2, 5'd1, 5'd3, 0, 0);
    #1 chk("lu_stall_pcw", 32'(pif.pc_write), 32'd0);
    chk("lu_stall_ifidw", 32'(pif.ifid_write), 32'd0);
    tick();
    chk("lu_bubble_ex", 32'(pif.ex_ctrl), 32'd0);
    chk("lu_release_pcw", 32'(pif.pc_write), 32'd1);
    tick();
    chk("lu_adds_ex", 32'(pif.ex_ctrl), 32'(mk(0, 0, 3'b010, 1, 0, 0, 4'b0000, 1, 0, 0, 5'd3)));
    chk("lu_wb_rd", 32'(pif.wb_ctrl.rd), 32'd2);
    chk("lu_wb_m2r", 32'(pif.wb_ctrl.mem2reg), 32'd1);

    // Load into XZR never stalls.
    do_reset();
    drive(11'b11111000010, 5'd1, 5'd0, 5'd31, 0, 0);
    tick();
    drive(11'b10101011000, 5'd31, 5'd1, 5'd3, 0, 0);
    #1 chk("xzr_pcw", 32'(pif.pc_write), 32'd1);

    // SUBS then B.LT: flag stall, then taken branch with flush.
    do_reset();
    drive(11'b11101011000, 5'd1, 5'd2, 5'd4, 0, 0);
    tick();
    drive(11'b01010100000, 5'd0, 5'd0, 5'd11, 0, 1);
    #1 chk("fu_stall_pcw", 32'(pif.pc_write), 32'd0);
    chk("fu_stall_pcsrc", 32'(pif.pc_src), 32'd0);
    chk("fu_stall_flush", 32'(pif.if_flush), 32'd0);
    tick();
    chk("fu_taken_pcsrc", 32'(pif.pc_src), 32'd1);
    chk("fu_taken_flush", 32'(pif.if_flush), 32'd1);
    chk("fu_taken_pcw", 32'(pif.pc_write), 32'd1);

    // CBZ not taken, then BL reaches WB with link register.
    do_reset();
    drive(11'b10110100000, 5'd0, 5'd0, 5'd5, 0, 0);
    #1 chk("cbz_nt_pcsrc", 32'(pif.pc_src), 32'd0);
    chk("cbz_nt_flush", 32'(pif.if_flush), 32'd0);
    drive(11'b10010100000, 5'd0, 5'd0, 5'd5, 0, 0);
    tick();
    drive(11'b10010001000, 5'd1, 5'd0, 5'd5, 0, 0);
    tick();
    tick();
    chk("bl_wb_rd", 32'(pif.wb_ctrl.rd), 32'd30);
    chk("bl_wb_spc", 32'(pif.wb_ctrl.store_pc), 32'd1);

    // Reset asserted during a load-use stall clears every stage.
    do_reset();
    drive(11'b11111000010, 5'd1, 5'd0, 5'd2, 0, 0);
    tick();
    drive(11'b10101011000, 5'd2, 5'd1, 5'd3, 0, 0);
    #1 chk("rs_stall_pcw", 32'(pif.pc_write), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_ex", 32'(pif.ex_ctrl), 32'd0);
    chk("rs_mem", 32'(pif.mem_ctrl), 32'd0);
    chk("rs_pcw", 32'(pif.pc_write), 32'd1);

    // Byte load opcode flowing to MEM.
    do_reset();
    drive(11'b00111000010, 5'd1, 5'd0, 5'd6, 0, 0);
    tick();
    drive(11'b10010001000, 5'd1, 5'd0, 5'd5, 0, 0);
`ifdef CTRL_BYTE_XFER_EN
    chk("byte_exill", 32'(pif.ex_illegal), 32'd0);
    tick();
    chk("byte_mem_xfer", 32'(pif.mem_ctrl.xfer), 32'd1);
    chk("byte_mem_rd", 32'(pif.mem_ctrl.mem_read), 32'd1);
`else
    chk("byte_exill", 32'(pif.ex_illegal), 32'd1);
    tick();
    chk("byte_mem", 32'(pif.mem_ctrl), 32'd0);
`endif

    // Random instruction stream against the pipeline model.
    pool = '{K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_CBZ, K_B, K_BL, K_BLT, K_BR, K_ILL, K_LDUR, K_BLT};
`ifdef CTRL_BYTE_XFER_EN
    pool.push_back(K_LDURB);
    pool.push_back(K_STURB);
`endif
    regs = '{5'd1, 5'd2, 5'd3, 5'd31};
    do_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 0; hold = 0;
    k = K_ADDI; op = '0; rn = '0; rm = '0; rt = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        k  = pool[$urandom_range(0, pool.size() - 1)];
        op = make_op(k);
        rn = regs[$urandom_range(0, 3)];
        rm = regs[$urandom_range(0, 3)];
        rt = regs[$urandom_range(0, 3)];
      end
      z = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      drive(op, rn, rm, rt, z, l);
      #1;
      lu = m_ex.mem_read && m_ex.rd != 5'd31 &&
           ((reads_rn(k) && m_ex.rd == rn) || (reads_rm(k) && m_ex.rd == rm) ||
            (reads_rt(k) && m_ex.rd == rt));
      fu = (k == K_BLT) && m_ex.update_flags;
      st = lu || fu;
      br_raw = (k == K_B) || (k == K_BL) || (k == K_CBZ && z) || (k == K_BLT && l);
      br_rel = br_raw && !st;
      chk("rnd_pcw", 32'(pif.pc_write), 32'(!st));
      chk("rnd_ifidw", 32'(pif.ifid_write), 32'(!st));
      chk("rnd_pcsrc", 32'(pif.pc_src), 32'(br_rel));
      chk("rnd_uncond", 32'(pif.uncond_br), 32'((k == K_B || k == K_BL) && !st));
      chk("rnd_fromreg", 32'(pif.pc_from_reg), 32'(k == K_BR && !st));
      chk("rnd_flush", 32'(pif.if_flush), 32'((br_raw || k == K_BR) && !st));
      chk("rnd_reg2loc", 32'(pif.id_reg2loc), 32'(k inside {K_STUR, K_STURB, K_CBZ}));
      chk("rnd_ex", 32'(pif.ex_ctrl), 32'(m_ex));
      chk("rnd_mem", 32'(pif.mem_ctrl), 32'(m_mem));
      chk("rnd_wb", 32'(pif.wb_ctrl), 32'(m_wb));
      chk("rnd_exill", 32'(pif.ex_illegal), 32'(m_ill));
      exp_b = kind_bundle(k, rt);
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = st ? '0 : exp_b;
      m_ill = !st && (k == K_ILL);
      hold  = st;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
